// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the pipeline MEM stage, the DMA/loader requester and data_memory.
// The arbiter takes the slave modport; requesters plus memory sit on the master side.
interface dmem_port_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int LOGSIZE = 12
);
  logic               p_req;
  logic               p_wr_en;
  logic [3:0]         p_byte_en;
  logic [LOGSIZE-1:0] p_addr;
  logic [WIDTH-1:0]   p_wdata;
  logic               p_stall;
  logic               p_rvalid;
  logic [WIDTH-1:0]   p_rdata;

  logic               d_valid;
  logic               d_ready;
  logic               d_wr_en;
  logic [3:0]         d_byte_en;
  logic [LOGSIZE-1:0] d_addr;
  logic [WIDTH-1:0]   d_wdata;
  logic               d_rvalid;
  logic [WIDTH-1:0]   d_rdata;

  logic [LOGSIZE-1:0] m_addr;
  logic [3:0]         m_byte_en;
  logic [WIDTH-1:0]   m_wdata;
  logic [WIDTH-1:0]   m_rdata;

  modport slave (
    input  p_req, p_wr_en, p_byte_en, p_addr, p_wdata,
    output p_stall, p_rvalid, p_rdata,
    input  d_valid, d_wr_en, d_byte_en, d_addr, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output m_addr, m_byte_en, m_wdata,
    input  m_rdata
  );

  modport master (
    output p_req, p_wr_en, p_byte_en, p_addr, p_wdata,
    input  p_stall, p_rvalid, p_rdata,
    output d_valid, d_wr_en, d_byte_en, d_addr, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_addr, m_byte_en, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline (priority) and a DMA requester,
// forcing one DMA grant after STARVE_MAX consecutive denials.
//
// state  | meaning
// NORMAL | pipeline wins; DMA denials counted in cnt
// FORCE  | one cycle where a valid DMA request wins and the pipeline stalls
module dmem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 4096,
  parameter int STARVE_MAX = 8
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               gnt_p;
  logic               gnt_d;
  logic               stall;
  logic [LOGSIZE-1:0] addr_mux;
  logic [3:0]         be_mux;
  logic [WIDTH-1:0]   wdata_mux;
  logic               p_rvalid_q;
  logic               d_rvalid_q;

  always_comb begin
    gnt_p = 1'b0;
    gnt_d = 1'b0;
    stall = 1'b0;
    if (state == FORCE) begin
      if (bus.d_valid) begin
        gnt_d = 1'b1;
        stall = bus.p_req;
      end else begin
        gnt_p = bus.p_req;
      end
    end else if (bus.p_req) begin
      gnt_p = 1'b1;
    end else if (bus.d_valid) begin
      gnt_d = 1'b1;
    end
  end

  // Reads present zero byte-enables so the memory never sees a spurious write.
  always_comb begin
    addr_mux  = '0;
    be_mux    = '0;
    wdata_mux = '0;
    if (gnt_p) begin
      addr_mux  = bus.p_addr;
      be_mux    = bus.p_wr_en ? bus.p_byte_en : 4'b0000;
      wdata_mux = bus.p_wdata;
    end else if (gnt_d) begin
      addr_mux  = bus.d_addr;
      be_mux    = bus.d_wr_en ? bus.d_byte_en : 4'b0000;
      wdata_mux = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      cnt        <= '0;
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      p_rvalid_q <= gnt_p & ~bus.p_wr_en;
      d_rvalid_q <= gnt_d & ~bus.d_wr_en;
      case (state)
        NORMAL: begin
          if (bus.d_valid && bus.p_req) begin
            if (cnt == CNT_LAST) begin
              state <= FORCE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        FORCE: begin
          state <= NORMAL;
          cnt   <= '0;
        end
        default: begin
          state <= NORMAL;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.m_addr    = addr_mux;
  assign bus.m_byte_en = be_mux;
  assign bus.m_wdata   = wdata_mux;
  assign bus.p_stall   = stall;
  assign bus.d_ready   = gnt_d;
  assign bus.p_rvalid  = p_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.p_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage and a secondary DMA/loader requester. It sits between the MEM-stage byte-enable/shift logic and `data_memory`. It drives the memory's word address, byte-enables and write data. It routes the 1-cycle synchronous read data back to the granted owner. The pipeline has priority, and a starvation counter forces a DMA grant, with a pipeline stall, after `STARVE_MAX` consecutive denials.

## Interface
- `WIDTH`, 32, data word width in bits.
- `SIZE`, 4096, memory depth in words; `LOGSIZE = $clog2(SIZE)` is a localparam.
- `STARVE_MAX`, 8, consecutive DMA denials before a forced DMA grant (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p_req`  in  1  pipeline requests a memory access this cycle.
- `p_wr_en`  in  1  pipeline access is a write.
- `p_byte_en`  in  4  pipeline byte write enables, already lane-aligned.
- `p_addr`  in  LOGSIZE  pipeline word address.
- `p_wdata`  in  WIDTH  pipeline write data, already lane-shifted.
- `p_stall`  out  1  pipeline must hold the MEM stage this cycle.
- `p_rvalid`  out  1  `p_rdata` carries the pipeline read issued last cycle.
- `p_rdata`  out  WIDTH  read data to the pipeline.
- `d_valid`  in  1  DMA request valid.
- `d_ready`  out  1  DMA request accepted this cycle.
- `d_wr_en`, `d_byte_en[3:0]`, `d_addr[LOGSIZE-1:0]`, `d_wdata[WIDTH-1:0]`  in  DMA request fields, with the same meaning as the pipeline fields.
- `d_rvalid`  out  1  `d_rdata` carries the DMA read accepted last cycle.
- `d_rdata`  out  WIDTH  read data to the DMA.
- `m_addr`  out  LOGSIZE  memory word address.
- `m_byte_en`  out  4  memory byte write enables.
- `m_wdata`  out  WIDTH  memory write data.
- `m_rdata`  in  WIDTH  memory read data, valid the cycle after the address is presented.

## Operation
- **Grant is combinational** from `state`, `p_req` and `d_valid`. One owner per cycle.
- **State NORMAL:**
  - If `p_req`, grant P.
  - Else if `d_valid`, grant D.
  - Else there is no grant.
- **State FORCE:**
  - If `d_valid`, grant D, and `p_stall = p_req`.
  - Else grant P if `p_req`; there is no stall.
- **Outputs when P is granted:** `m_*` carry the P fields. `m_byte_en = p_wr_en ? p_byte_en : 0`.
- **Outputs when D is granted:** `m_*` carry the D fields. `m_byte_en = d_wr_en ? d_byte_en : 0`. `d_ready = 1`.
- **Outputs with no grant:** `m_addr = 0`, `m_byte_en = 0`, `m_wdata = 0`.
- **`p_stall`** is 1 only in FORCE with `d_valid & p_req`; it is 0 otherwise. `d_ready` is 0 whenever D is not granted.
- **Starvation counter `cnt`** is `$clog2(STARVE_MAX+1)` bits wide.
  - In NORMAL with `d_valid & p_req`, `cnt` increments.
  - When the increment would reach `STARVE_MAX`, the next state is FORCE and `cnt` clears.
  - In NORMAL, any D grant or `!d_valid` clears `cnt`.
  - `cnt` never wraps.
- **Transitions:**
  - NORMAL to FORCE: on the `STARVE_MAX`-th consecutive denial.
  - FORCE to NORMAL: after exactly one cycle, whether or not D was granted. `cnt` stays 0.
- **Read return:**
  - `p_rvalid` is a flop, set on a P grant with `!p_wr_en`.
  - `d_rvalid` is a flop, set on a D grant with `!d_wr_en`.
  - `p_rdata = m_rdata` and `d_rdata = m_rdata`, unregistered.
- **Reset:** when `reset` is low, `state = NORMAL`, `cnt = 0`, `p_rvalid = 0`, `d_rvalid = 0`, effective immediately and asynchronously.
  - Combinational outputs follow the NORMAL rules during reset.
  - A read in flight when reset asserts produces no rvalid.

## Timing
- **Write:** committed at the rising edge that ends the grant cycle.
- **Read latency:** 1 cycle. Data and the matching rvalid appear in the cycle after the grant.
- **Stalled pipeline:** holds its request fields. Its access is granted in the cycle after the forced D grant.
- **Back-to-back accesses:** a D write to address A followed by a P read of A returns the new data. There is no extra arbiter delay.
- **Maximum DMA wait** under continuous `p_req` is `STARVE_MAX` cycles. The grant happens in cycle `STARVE_MAX+1` after `d_valid` rises.
- **Simultaneous `d_valid` drop and FORCE entry:** FORCE grants P, then returns to NORMAL.

## Test plan
- **DMA only:** D writes 0xDEADBEEF to addr 5 with byte_en 1111, then reads addr 5.
  - `d_ready = 1` in both cycles, and `p_stall` stays 0.
  - `d_rvalid = 1` and `d_rdata = 0xDEADBEEF` one cycle after the read.
- **Starvation with STARVE_MAX=8:** `p_req` is held with reads of addr 0, and `d_valid` is raised at cycle 1.
  - Cycles 1–8: `d_ready = 0`, `p_stall = 0`, `m_addr = 0`.
  - Cycle 9: `d_ready = 1`, `p_stall = 1`, `m_addr = d_addr`.
  - Cycle 10: P is granted again and `cnt` restarts from 0.
- **DMA gives up:** `d_valid` drops in the FORCE cycle. Then `p_stall = 0`, P is granted, `d_ready = 0`, and state returns to NORMAL.
- **Byte lane:** addr 3 holds 0x11223344. P writes with byte_en 0100 and wdata 0x00AB0000. A following D read of addr 3 returns 0x11AB3344 with `d_rvalid = 1` and `p_rvalid = 0`.
- **Async reset in FORCE:** `reset` is driven low between clock edges while a D read is pending.
  - `d_rvalid = 0` immediately, state is NORMAL, and `cnt = 0`.
  - After release, `p_req` is granted on the first cycle.
